stopwatch_core: RTL
===================

// Module: stopwatch_core
// PURPOSE
// - Count-up stopwatch engine. Sits downstream of debounce_wrapper and upstream of display_driver.
// - Consumes debounced start/stop/clear levels and the 1 kHz divider output.
// - Produces minutes/seconds for display_driver and blink for blinking_display.
// - Counts 00:00 to 59:59, then saturates.
// PARAMETERS
// - TICKS_PER_SEC  1000  clk1k rising edges per counted second (bench uses 4)
// - MAX_MINUTES    59    minutes value at which the count saturates (with seconds = 59)
// PORTS
// - clk      in   1  system clock, 100 MHz
// - rst      in   1  synchronous, active-high reset
// - clk1k    in   1  1 kHz square wave from clock_divider, synchronous to clk; sampled as data, never used as a clock
// - en       in   1  global enable; 0 freezes all counting (FSM still accepts commands)
// - start    in   1  debounced start level; acts on rising edge
// - stop     in   1  debounced stop level; acts on rising edge
// - clear    in   1  debounced soft-reset level; acts on rising edge
// - lap      in   1  debounced lap level; acts on rising edge (present only with STOPWATCH_LAP_EN)
// - minutes  out  6  displayed minutes, 0..MAX_MINUTES
// - seconds  out  6  displayed seconds, 0..59
// - running  out  1  1 while in RUN
// - blink    out  1  request to blinking_display; 1 in PAUSE and SAT
// BEHAVIOUR
// - Reset: state=IDLE; minutes=0, seconds=0, tick_cnt=0, running=0, blink=0; all edge-detect history regs = 0.
//   - Consequence: an input held high through reset produces an edge on the first cycle after reset.
// - Edge detect: X_q <= X each cycle; X_rise = X & ~X_q, for start, stop, clear, lap and clk1k (tick = clk1k_rise).
// - Command priority (same cycle): clear > stop > start.
// - FSM states: IDLE, RUN, PAUSE, SAT.
//   - IDLE:  start_rise -> RUN.
//   - RUN:   stop_rise -> PAUSE; increment would pass MAX_MINUTES:59 -> SAT.
//   - PAUSE: start_rise -> RUN, resumes with tick_cnt preserved.
//   - SAT:   start/stop ignored; only clear exits.
//   - Any state: clear_rise -> IDLE; minutes, seconds and tick_cnt zeroed at the next edge.
//   - start_rise in RUN and stop_rise in IDLE/PAUSE are ignored.
// - Counting happens only in RUN with en=1 and tick=1, and no stop/clear edge in that cycle.
//   - A tick coinciding with a stop_rise or clear_rise is discarded.
//   - A tick coinciding with the start_rise that enters RUN is also discarded; counting begins the following cycle.
// - tick_cnt: 0..TICKS_PER_SEC-1, width $clog2(TICKS_PER_SEC).
//   - At TICKS_PER_SEC-1 a tick wraps it to 0 and advances the time by 1 s.
//   - seconds 59 -> 0 with minutes+1.
//   - At MAX_MINUTES:59 the advance is suppressed: outputs hold MAX_MINUTES:59, tick_cnt = 0, state -> SAT.
// - Latency: all outputs registered; a tick (or command edge) in cycle N is visible on outputs in cycle N+1.
// - running = (state==RUN); blink = (state==PAUSE || state==SAT); both registered with the state.
// - en=0: tick ignored, tick_cnt holds; commands still change state.
// - rst mid-count overrides everything, including same-cycle edges.
// CONFIGURATION
// - STOPWATCH_LAP_EN defined:
//   - lap port exists; lap_rise in RUN freezes minutes/seconds into a hold register and sets lap_hold=1.
//   - Outputs show the frozen value while internal counting continues.
//   - A second lap_rise, or stop_rise, clears lap_hold and outputs show the live count again next cycle.
//   - clear also clears lap_hold; lap_rise is ignored outside RUN.
//   - In SAT, lap_hold is forced to 0.
// - STOPWATCH_LAP_EN undefined: no lap port, no hold register; outputs always show the live count.
// TESTING
// - TICKS_PER_SEC=4; reset, start pulse, 8 clk1k edges -> 00:02, running=1, blink=0.
// - Counting at 00:02 with tick_cnt=2, stop pulse -> PAUSE, blink=1, 5 ticks keep 00:02.
//   - Start pulse, then 2 ticks -> 00:03 (tick_cnt resumes from 2).
// - Preload to 00:59 via counting, tick_cnt=3, one tick -> 01:00.
//   - At 59:59, 4 ticks -> stays 59:59, state SAT, blink=1, running=0; start ignored; clear -> 00:00 IDLE.
// - Simultaneous clear+stop+start rise with a tick in RUN -> next cycle IDLE, 00:00, tick not counted.
// - en=0 in RUN for 12 ticks -> time unchanged; en=1 resumes from the same tick_cnt.
// - STOPWATCH_LAP_EN: RUN at 00:05, lap pulse, 8 ticks -> outputs 00:05, internal 00:07.
//   - Second lap pulse -> outputs 00:07 the next cycle.

Source files
------------

// File: rtl/stopwatch_core.sv
// Count-up mm:ss stopwatch engine driven by a 1 kHz tick sampled as data; saturates at MAX_MINUTES:59.
// Optional lap-hold display freeze is compiled in with the STOPWATCH_LAP_EN macro.
module stopwatch_core #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MAX_MINUTES   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk1k,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       blink,
    output logic [1:0] dbg_state
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    MIN_LAST  = 6'(MAX_MINUTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SAT} state_t;

    state_t        state_q, state_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          running_q, blink_q;
    logic          start_q, stop_q, clear_q, clk1k_q;
    logic          start_rise, stop_rise, clear_rise, tick, count_en;

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop  & ~stop_q;
    assign clear_rise = clear & ~clear_q;
    assign tick       = clk1k & ~clk1k_q;
    // A tick is lost if a stop or clear edge lands in the same cycle.
    assign count_en   = (state_q == S_RUN) && en && tick && !stop_rise && !clear_rise;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = tick_q;
        if (clear_rise) begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE:  if (start_rise) state_d = S_RUN;
                S_RUN:   if (stop_rise)  state_d = S_PAUSE;
                S_PAUSE: if (start_rise) state_d = S_RUN;
                default: ;
            endcase
            if (count_en) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (sec_q == 6'd59) begin
                        if (min_q == MIN_LAST) begin
                            state_d = S_SAT;
                        end else begin
                            sec_d = '0;
                            min_d = min_q + 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            tick_q    <= '0;
            running_q <= 1'b0;
            blink_q   <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            clear_q   <= 1'b0;
            clk1k_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            running_q <= (state_d == S_RUN);
            blink_q   <= (state_d == S_PAUSE) || (state_d == S_SAT);
            start_q   <= start;
            stop_q    <= stop;
            clear_q   <= clear;
            clk1k_q   <= clk1k;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_q, lap_rise;
    logic       lap_hold_q, lap_hold_d;
    logic [5:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;

    assign lap_rise = lap & ~lap_q;

    // The hold captures the live value present before this cycle's tick.
    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_min_d  = lap_min_q;
        lap_sec_d  = lap_sec_q;
        if (clear_rise || stop_rise || state_d == S_SAT) begin
            lap_hold_d = 1'b0;
        end else if (lap_rise && state_q == S_RUN) begin
            lap_hold_d = ~lap_hold_q;
            if (!lap_hold_q) begin
                lap_min_d = min_q;
                lap_sec_d = sec_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q      <= 1'b0;
            lap_hold_q <= 1'b0;
            lap_min_q  <= '0;
            lap_sec_q  <= '0;
        end else begin
            lap_q      <= lap;
            lap_hold_q <= lap_hold_d;
            lap_min_q  <= lap_min_d;
            lap_sec_q  <= lap_sec_d;
        end
    end

    assign minutes = lap_hold_q ? lap_min_q : min_q;
    assign seconds = lap_hold_q ? lap_sec_q : sec_q;
`else
    assign minutes = min_q;
    assign seconds = sec_q;
`endif

    assign running   = running_q;
    assign blink     = blink_q;
    assign dbg_state = state_q;
endmodule
